// File: rtl/phy_rx_deframer_pkg.sv
// Shared definitions for the PHY receive deframer: FSM state encoding,
// preamble/SFD nibble values, CRC-32 constants and f_ctrl_out field layout.
// The optional CRC checker is enabled by defining RX_CRC_CHECK_EN.
package phy_rx_deframer_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PREAMBLE = 2'd1;
   localparam logic [1:0] ST_DATA     = 2'd2;
   localparam logic [1:0] ST_DROP     = 2'd3;

   localparam logic [3:0] NIB_PREAMBLE = 4'h5;
   localparam logic [3:0] NIB_SFD      = 4'hD;

   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

   localparam int CTRL_WIDTH     = 24;
   localparam int CTRL_CNT_LSB   = 0;
   localparam int CTRL_CNT_MSB   = 11;
   localparam int CTRL_ALIGN_BIT = 12;
   localparam int CTRL_LEN_BIT   = 13;
   localparam int CTRL_CRC_BIT   = 14;

   localparam logic [11:0] BYTE_CNT_MAX = 12'hFFF;
   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

   // Assemble the frame control word; unused upper bits stay zero.
   function automatic logic [CTRL_WIDTH-1:0] pack_ctrl(
      input logic [11:0] cnt,
      input logic        align_err,
      input logic        len_err,
      input logic        crc_err
   );
      logic [CTRL_WIDTH-1:0] w;
      w = '0;
      w[CTRL_CNT_MSB:CTRL_CNT_LSB] = cnt;
      w[CTRL_ALIGN_BIT]            = align_err;
      w[CTRL_LEN_BIT]              = len_err;
      w[CTRL_CRC_BIT]              = crc_err;
      return w;
   endfunction

endpackage

// File: rtl/phy_rx_deframer_crc32_byte_update.sv
// One byte of reflected CRC-32 (poly 0x04C11DB7), LSB of the byte first.
// Purely combinational; the deframer holds the running register.
module crc32_byte_update
   import phy_rx_deframer_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   // Eight unrolled shift/xor steps of the reflected LFSR.
   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data_in[i])
            c = (c >> 1) ^ CRC_POLY_REFL;
         else
            c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/phy_rx_deframer.sv
// PHY receive deframer: strips preamble/SFD from a nibble stream, rebuilds
// bytes (low nibble first), enforces MIN_LEN/MAX_LEN and reports a control
// word per frame. Define RX_CRC_CHECK_EN to build the FCS residue check.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for phy_rx_dv; only a clean 0x5 start is accepted
// ST_PREAMBLE | consuming 0x5 nibbles until the 0xD SFD nibble
// ST_DATA     | pairing nibbles into bytes, counting, emitting payload
// ST_DROP     | discarding a malformed frame until phy_rx_dv falls
module phy_rx_deframer
   import phy_rx_deframer_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 2047
) (
   input  logic        clk_phy,
   input  logic        reset_n,
   input  logic        phy_rx_dv,
   input  logic [3:0]  phy_data_in,
   output logic [7:0]  f_data_out,
   output logic        f_data_valid,
   output logic        f_frame_start,
   output logic [23:0] f_ctrl_out,
   output logic        f_ctrl_valid,
   output logic [15:0] drop_cnt
);

   localparam logic [31:0] MIN_LEN_U = 32'(MIN_LEN);
   localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

   logic [1:0]  state, state_nxt;
   logic [3:0]  low_nib;
   logic        half;
   logic [11:0] byte_cnt;
   logic        armed;
   logic        sfd_seen;
   logic        byte_done;
   logic        frame_end;
   logic        drop_enter;
   logic        emit;
   logic        len_err;
   logic        crc_err;
   logic [7:0]  byte_val;
   logic [31:0] cnt_ext;

   assign byte_val = {phy_data_in, low_nib};
   assign cnt_ext  = {20'd0, byte_cnt};
   assign emit     = byte_done && (cnt_ext < MAX_LEN_U);
   assign len_err  = (cnt_ext < MIN_LEN_U) || (cnt_ext > MAX_LEN_U);

   // Next-state decode plus one-cycle event flags for the datapath.
   always_comb begin
      state_nxt  = state;
      sfd_seen   = 1'b0;
      byte_done  = 1'b0;
      frame_end  = 1'b0;
      drop_enter = 1'b0;
      case (state)
         ST_IDLE: begin
            // armed is low when dv was already high in the previous cycle
            // (e.g. released from reset mid-frame): that frame is dropped.
            if (phy_rx_dv) begin
               if (armed && (phy_data_in == NIB_PREAMBLE)) begin
                  state_nxt = ST_PREAMBLE;
               end else begin
                  state_nxt  = ST_DROP;
                  drop_enter = 1'b1;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!phy_rx_dv) begin
               state_nxt = ST_IDLE;
            end else if (phy_data_in == NIB_SFD) begin
               state_nxt = ST_DATA;
               sfd_seen  = 1'b1;
            end else if (phy_data_in != NIB_PREAMBLE) begin
               state_nxt  = ST_DROP;
               drop_enter = 1'b1;
            end
         end
         ST_DATA: begin
            if (!phy_rx_dv) begin
               state_nxt = ST_IDLE;
               frame_end = 1'b1;
            end else if (half) begin
               byte_done = 1'b1;
            end
         end
         ST_DROP: begin
            if (!phy_rx_dv)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM state, nibble pairing and the saturating byte counter.
   always_ff @(posedge clk_phy or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         armed    <= 1'b0;
         half     <= 1'b0;
         low_nib  <= 4'h0;
         byte_cnt <= 12'd0;
      end else begin
         state <= state_nxt;
         armed <= !phy_rx_dv;
         if (sfd_seen) begin
            half     <= 1'b0;
            byte_cnt <= 12'd0;
         end else if ((state == ST_DATA) && phy_rx_dv) begin
            half <= !half;
            if (!half)
               low_nib <= phy_data_in;
            if (byte_done && (byte_cnt != BYTE_CNT_MAX))
               byte_cnt <= byte_cnt + 12'd1;
         end else begin
            half <= 1'b0;
         end
      end
   end

`ifdef RX_CRC_CHECK_EN
   logic [31:0] crc_q;
   logic [31:0] crc_nxt;

   crc32_byte_update u_crc (
      .crc_in  (crc_q),
      .data_in (byte_val),
      .crc_out (crc_nxt)
   );

   // Running CRC over every DATA byte, including those past MAX_LEN.
   always_ff @(posedge clk_phy or negedge reset_n) begin
      if (!reset_n)
         crc_q <= 32'd0;
      else if (sfd_seen)
         crc_q <= CRC_INIT;
      else if (byte_done)
         crc_q <= crc_nxt;
   end

   assign crc_err = (crc_q != CRC_RESIDUE);
`else
   assign crc_err = 1'b0;
`endif

   // Registered payload and control outputs.
   always_ff @(posedge clk_phy or negedge reset_n) begin
      if (!reset_n) begin
         f_data_out    <= 8'd0;
         f_data_valid  <= 1'b0;
         f_frame_start <= 1'b0;
         f_ctrl_out    <= 24'd0;
         f_ctrl_valid  <= 1'b0;
      end else begin
         f_data_valid  <= emit;
         f_frame_start <= emit && (byte_cnt == 12'd0);
         f_ctrl_valid  <= frame_end;
         if (emit)
            f_data_out <= byte_val;
         if (frame_end)
            f_ctrl_out <= pack_ctrl(byte_cnt, half, len_err, crc_err);
      end
   end

   // Saturating count of frames sent to ST_DROP.
   always_ff @(posedge clk_phy or negedge reset_n) begin
      if (!reset_n)
         drop_cnt <= 16'd0;
      else if (drop_enter && (drop_cnt != DROP_CNT_MAX))
         drop_cnt <= drop_cnt + 16'd1;
   end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer: drivers push expected bytes and
// control words as stimulus goes in; a negedge monitor pops and compares.
module tb_phy_rx_deframer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 2047;

   logic        clk_phy = 1'b0;
   logic        reset_n;
   logic        phy_rx_dv;
   logic [3:0]  phy_data_in;
   logic [7:0]  f_data_out;
   logic        f_data_valid;
   logic        f_frame_start;
   logic [23:0] f_ctrl_out;
   logic        f_ctrl_valid;
   logic [15:0] drop_cnt;

   phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .clk_phy       (clk_phy),
      .reset_n       (reset_n),
      .phy_rx_dv     (phy_rx_dv),
      .phy_data_in   (phy_data_in),
      .f_data_out    (f_data_out),
      .f_data_valid  (f_data_valid),
      .f_frame_start (f_frame_start),
      .f_ctrl_out    (f_ctrl_out),
      .f_ctrl_valid  (f_ctrl_valid),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk_phy = ~clk_phy;

   typedef struct {
      logic [7:0] b;
      logic       st;
   } exp_byte_t;

   typedef struct {
      logic [23:0] w;
      time         t;
   } exp_ctrl_t;

   exp_byte_t  exp_q[$];
   exp_ctrl_t  ctrl_q[$];
   logic [7:0] fb[$];
   exp_byte_t  eb;
   exp_ctrl_t  ec;
   int         n_vec = 0;
   int         n_err = 0;
   int         data_seen = 0;

   // Monitor: compare every output event against the scoreboard.
   always @(negedge clk_phy) begin
      if (f_data_valid === 1'b1) begin
         data_seen++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL data_unexpected: got %02h, required no byte", f_data_out);
         end else begin
            eb = exp_q.pop_front();
            if (f_data_out !== eb.b || f_frame_start !== eb.st) begin
               n_err++;
               $display("FAIL data_byte: got %02h start %b, required %02h start %b",
                        f_data_out, f_frame_start, eb.b, eb.st);
            end
         end
      end else if (f_frame_start !== 1'b0) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_start: got f_frame_start %b without data, required 0", f_frame_start);
      end
      if (f_ctrl_valid === 1'b1) begin
         n_vec++;
         if (ctrl_q.size() == 0) begin
            n_err++;
            $display("FAIL ctrl_unexpected: got %06h, required no ctrl", f_ctrl_out);
         end else begin
            ec = ctrl_q.pop_front();
            if (f_ctrl_out !== ec.w || $time != ec.t) begin
               n_err++;
               $display("FAIL ctrl_word: got %06h at %0t, required %06h at %0t",
                        f_ctrl_out, $time, ec.w, ec.t);
            end
         end
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ d[i]) == 1'b1)
            c = (c >> 1) ^ 32'hEDB8_8320;
         else
            c = c >> 1;
      end
      return c;
   endfunction

   task automatic send_nib(input logic dv, input logic [3:0] n);
      @(posedge clk_phy);
      #1;
      phy_rx_dv   = dv;
      phy_data_in = n;
   endtask

   task automatic idle(input int n);
      repeat (n) send_nib(1'b0, 4'h0);
   endtask

   // Drive preamble, SFD, the bytes in fb, an optional stray nibble and one
   // dv-low cycle; expectations are queued as the stimulus goes out.
   task automatic send_frame(input int npre, input logic extra, input logic [3:0] extra_nib);
      int          n;
      logic [31:0] c;
      logic [23:0] w;
      n = fb.size();
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < npre; i++) send_nib(1'b1, 4'h5);
      send_nib(1'b1, 4'hD);
      for (int i = 0; i < n; i++) begin
         send_nib(1'b1, fb[i][3:0]);
         send_nib(1'b1, fb[i][7:4]);
         c = crc_upd(c, fb[i]);
         if (i < MAX_LEN) exp_q.push_back('{b: fb[i], st: (i == 0)});
      end
      if (extra) send_nib(1'b1, extra_nib);
      w = 24'd0;
      w[11:0] = (n > 4095) ? 12'hFFF : n[11:0];
      w[12]   = extra;
      w[13]   = (n < MIN_LEN) || (n > MAX_LEN);
`ifdef RX_CRC_CHECK_EN
      w[14]   = (c != 32'hDEBB_20E3);
`endif
      send_nib(1'b0, 4'h0);
      ctrl_q.push_back('{w: w, t: $time + 14});
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      phy_rx_dv   = 1'b0;
      phy_data_in = 4'h0;
      repeat (3) @(posedge clk_phy);
      @(negedge clk_phy);
      n_vec++; if (f_data_out !== 8'd0) begin n_err++; $display("FAIL rst_data_out: got %02h, required 00", f_data_out); end
      n_vec++; if (f_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_data_valid: got %b, required 0", f_data_valid); end
      n_vec++; if (f_frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame_start: got %b, required 0", f_frame_start); end
      n_vec++; if (f_ctrl_out !== 24'd0) begin n_err++; $display("FAIL rst_ctrl_out: got %06h, required 000000", f_ctrl_out); end
      n_vec++; if (f_ctrl_valid !== 1'b0) begin n_err++; $display("FAIL rst_ctrl_valid: got %b, required 0", f_ctrl_valid); end
      n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
      @(posedge clk_phy);
      #1 reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_drop;
      int seen0;
      seen0 = data_seen;
      send_nib(1'b1, 4'h3);
      for (int i = 0; i < 6; i++) send_nib(1'b1, 4'($urandom_range(0, 15)));
      idle(3);
      @(negedge clk_phy);
      n_vec++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL drop_bad_start: got %0d, required 1", drop_cnt); end
      send_nib(1'b1, 4'h5);
      send_nib(1'b1, 4'h5);
      send_nib(1'b1, 4'h7);
      send_nib(1'b1, 4'h5);
      idle(3);
      @(negedge clk_phy);
      n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL drop_bad_preamble: got %0d, required 2", drop_cnt); end
      n_vec++; if (data_seen != seen0 || ctrl_q.size() != 0) begin n_err++; $display("FAIL drop_outputs: got %0d bytes, required 0", data_seen - seen0); end
   endtask

   task automatic test_512;
      fb.delete();
      for (int i = 0; i < 4; i++) fb.push_back(8'h33);
      for (int i = 0; i < 504; i++) fb.push_back(8'hFF);
      for (int i = 0; i < 4; i++) fb.push_back(8'h33);
      data_seen = 0;
      send_frame(15, 1'b0, 4'h0);
      idle(3);
      n_vec++; if (data_seen != 512) begin n_err++; $display("FAIL f512_count: got %0d, required 512", data_seen); end
      n_vec++; if (exp_q.size() != 0 || ctrl_q.size() != 0) begin n_err++; $display("FAIL f512_pending: got %0d/%0d, required 0/0", exp_q.size(), ctrl_q.size()); end
   endtask

   task automatic test_length;
      int lens[5] = '{63, 64, 0, 2047, 2050};
      int want;
      for (int k = 0; k < 5; k++) begin
         fb.delete();
         for (int i = 0; i < lens[k]; i++) fb.push_back(8'($urandom_range(0, 255)));
         data_seen = 0;
         send_frame(7, 1'b0, 4'h0);
         idle(3);
         want = (lens[k] > MAX_LEN) ? MAX_LEN : lens[k];
         n_vec++; if (data_seen != want) begin n_err++; $display("FAIL len_%0d_count: got %0d, required %0d", lens[k], data_seen, want); end
         n_vec++; if (exp_q.size() != 0 || ctrl_q.size() != 0) begin n_err++; $display("FAIL len_%0d_pending: got %0d/%0d, required 0/0", lens[k], exp_q.size(), ctrl_q.size()); end
      end
   endtask

   task automatic test_align;
      fb.delete();
      for (int i = 0; i < 100; i++) fb.push_back(8'($urandom_range(0, 255)));
      data_seen = 0;
      send_frame(7, 1'b1, 4'hA);
      idle(3);
      n_vec++; if (data_seen != 100) begin n_err++; $display("FAIL align_count: got %0d, required 100", data_seen); end
      n_vec++; if (ctrl_q.size() != 0) begin n_err++; $display("FAIL align_pending: got %0d, required 0", ctrl_q.size()); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] d0;
      d0 = drop_cnt;
      data_seen = 0;
      fb.delete();
      for (int i = 0; i < 70; i++) fb.push_back(8'($urandom_range(0, 255)));
      send_frame(7, 1'b0, 4'h0);
      fb.delete();
      for (int i = 0; i < 80; i++) fb.push_back(8'($urandom_range(0, 255)));
      send_frame(1, 1'b0, 4'h0);
      idle(3);
      n_vec++; if (data_seen != 150) begin n_err++; $display("FAIL b2b_count: got %0d, required 150", data_seen); end
      n_vec++; if (drop_cnt !== d0) begin n_err++; $display("FAIL b2b_drop: got %0d, required %0d", drop_cnt, d0); end
      n_vec++; if (exp_q.size() != 0 || ctrl_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d/%0d, required 0/0", exp_q.size(), ctrl_q.size()); end
   endtask

   task automatic test_reset_mid;
      data_seen = 0;
      for (int i = 0; i < 7; i++) send_nib(1'b1, 4'h5);
      send_nib(1'b1, 4'hD);
      for (int i = 0; i < 200; i++) begin
         send_nib(1'b1, 4'h5);
         send_nib(1'b1, 4'h5);
         exp_q.push_back('{b: 8'h55, st: (i == 0)});
      end
      send_nib(1'b1, 4'h5);
      @(posedge clk_phy);
      #1 reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_nib(1'b1, 4'h5);
         @(negedge clk_phy);
         n_vec++;
         if ({f_data_out, f_data_valid, f_frame_start, f_ctrl_out, f_ctrl_valid, drop_cnt} !== 51'd0) begin
            n_err++;
            $display("FAIL midrst_outputs: got data %02h v %b ctrl %06h cv %b drop %0d, required all 0",
                     f_data_out, f_data_valid, f_ctrl_out, f_ctrl_valid, drop_cnt);
         end
      end
      @(posedge clk_phy);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 40; i++) send_nib(1'b1, 4'h5);
      idle(3);
      @(negedge clk_phy);
      n_vec++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_drop: got %0d, required 1", drop_cnt); end
      n_vec++; if (data_seen != 200) begin n_err++; $display("FAIL midrst_count: got %0d, required 200", data_seen); end
      n_vec++; if (exp_q.size() != 0 || ctrl_q.size() != 0) begin n_err++; $display("FAIL midrst_pending: got %0d/%0d, required 0/0", exp_q.size(), ctrl_q.size()); end
   endtask

`ifdef RX_CRC_CHECK_EN
   task automatic test_crc;
      logic [31:0] c;
      for (int k = 0; k < 2; k++) begin
         fb.delete();
         c = 32'hFFFF_FFFF;
         for (int i = 0; i < 60; i++) begin
            fb.push_back(8'($urandom_range(0, 255)));
            c = crc_upd(c, fb[i]);
         end
         c = ~c;
         fb.push_back(c[7:0]);
         fb.push_back(c[15:8]);
         fb.push_back(c[23:16]);
         fb.push_back(c[31:24]);
         if (k == 1) fb[62] = fb[62] ^ 8'h10;
         data_seen = 0;
         send_frame(7, 1'b0, 4'h0);
         idle(3);
         n_vec++; if (data_seen != 64 || ctrl_q.size() != 0) begin n_err++; $display("FAIL crc_%0d: got %0d bytes, required 64", k, data_seen); end
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_drop();
      test_512();
      test_length();
      test_align();
      test_back_to_back();
`ifdef RX_CRC_CHECK_EN
      test_crc();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/phy_rx_deframer.md
PHY_RX_DEFRAMER -- requirements
Module: phy_rx_deframer

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes, counted after the start-of-frame delimiter (SFD) and including the frame check sequence (FCS).
REQ-002 Parameter MAX_LEN, default 2047, maximum legal frame length in bytes, counted the same way as MIN_LEN.
REQ-003 Port clk_phy, input, width 1: the single clock; all logic is on the rising edge.
REQ-004 Port reset_n, input, width 1: asynchronous, active-low reset.
REQ-005 Port phy_rx_dv, input, width 1: receive data valid from the PHY.
REQ-006 Port phy_data_in, input, width 4: receive nibble, low nibble of each byte first.
REQ-007 Port f_data_out, output, width 8: reassembled payload byte.
REQ-008 Port f_data_valid, output, width 1: f_data_out is valid this cycle.
REQ-009 Port f_frame_start, output, width 1: coincident with the first f_data_valid of a frame.
REQ-010 Port f_ctrl_out, output, width 24: frame control block; bits [11:0] = byte count, bit 12 = alignment error, bit 13 = length error, bit 14 = CRC error, bits [23:15] = 0.
REQ-011 Port f_ctrl_valid, output, width 1: one-cycle strobe qualifying f_ctrl_out.
REQ-012 Port drop_cnt, output, width 16: count of dropped frames.

Function
REQ-013 The FSM SHALL have four states: IDLE, PREAMBLE, DATA and DROP.
REQ-014 From IDLE, phy_rx_dv=1 with nibble 0x5 SHALL go to PREAMBLE; phy_rx_dv=1 with any other nibble SHALL go to DROP.
REQ-015 In PREAMBLE: nibble 0x5 stays; nibble 0xD (SFD high nibble) goes to DATA; any other nibble goes to DROP; phy_rx_dv=0 returns to IDLE with no output.
REQ-016 In DATA, nibbles SHALL pair low-then-high; f_data_out/f_data_valid SHALL be registered one cycle after the high nibble.
REQ-017 The byte counter SHALL reset to 0 on SFD, increment per byte, and saturate at 4095.
REQ-018 Bytes beyond MAX_LEN SHALL NOT be emitted; they are still counted.
REQ-019 phy_rx_dv falling in DATA SHALL assert f_ctrl_valid exactly one cycle after the first cycle with phy_rx_dv=0, then go to IDLE.
REQ-020 Alignment error SHALL be set when DATA ends on an unpaired low nibble; that nibble is discarded.
REQ-021 Length error SHALL be set when count < MIN_LEN or count > MAX_LEN.
REQ-022 DROP SHALL wait for phy_rx_dv=0, then go to IDLE; each entry into DROP SHALL increment drop_cnt, saturating at 0xFFFF; DROP emits no data and no ctrl.
REQ-023 phy_rx_dv reasserting in the same cycle f_ctrl_valid pulses SHALL be accepted as a new frame start, with no lost nibble.
REQ-024 A zero-byte frame (SFD immediately followed by phy_rx_dv=0) SHALL produce f_ctrl_valid with count 0 and the length error bit set.

Reset
REQ-025 While reset_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counters and CRC register SHALL be cleared, including when reset is asserted mid-frame.
REQ-026 After reset release, a frame already in progress (phy_rx_dv=1 at release) SHALL go to DROP.

Configuration
REQ-027 With macro RX_CRC_CHECK_EN defined, a CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL run over all DATA bytes.
REQ-028 With RX_CRC_CHECK_EN defined, bit 14 SHALL be set if the final register is not equal to the residue 0xDEBB20E3.
REQ-029 Without RX_CRC_CHECK_EN, no CRC logic SHALL be built and bit 14 SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the constants 0x5, 0xD and 0xDEBB20E3, and the f_ctrl_out bit-field positions.
REQ-031 The byte-wise CRC update SHALL be one sub-module, crc32_byte_update, instantiated only under RX_CRC_CHECK_EN.

Verification
REQ-032 Bench SHALL cover: preamble 15x 0x5, SFD, 512 bytes (0x33 x4, 0xFF x504, 0x33 x4), then dv low -> 512 f_data_valid pulses, f_frame_start on the first, f_ctrl_out=0x000200, f_ctrl_valid one cycle after dv falls.
REQ-033 Bench SHALL cover: a 63-byte frame -> f_ctrl_out=0x00203F; a 2050-byte frame -> 2047 bytes emitted, f_ctrl_out=0x002802.
REQ-034 Bench SHALL cover: a 100-byte frame plus one extra nibble -> 100 bytes emitted, f_ctrl_out=0x001064.
REQ-035 Bench SHALL cover: a frame starting with nibble 0x3 -> no outputs, drop_cnt 0->1; a second frame whose dv rises in the same cycle as f_ctrl_valid -> both frames received intact.
REQ-036 Bench SHALL cover: reset_n pulsed low at byte 200 of a frame -> outputs 0; frame dropped after release; drop_cnt=1.
REQ-037 Bench SHALL cover, under RX_CRC_CHECK_EN: a 64-byte frame with valid FCS -> bit 14=0; the same frame with one FCS bit flipped -> bit 14=1.
